// File: rtl/spi_ctrl_fifo.sv
// SPI control glue: TX/RX FIFOs between the register file and the SPI shifters, with
// single-cycle load/ack handshakes, registered enables and sticky overflow flags.
// Optional interrupt output is built only when SPI_CTRL_IRQ_EN is defined.
module spi_ctrl_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          CLR_N,
    input  logic [7:0]    CONTROL,
    input  logic          WRITE,
    input  logic [DW-1:0] WDATA,
    input  logic          READ,
    output logic [DW-1:0] RDATA,
    output logic [7:0]    STATUS,
    output logic [CW-1:0] TX_COUNT,
    output logic [CW-1:0] RX_COUNT,
    input  logic          SENDER_EMPTY_STATE,
    output logic          SENDER_WRITE,
    output logic [DW-1:0] SENDER_DATA,
    output logic          TE,
    output logic          RE,
    input  logic          RECEIVER_FULL_STATE,
    input  logic [DW-1:0] RECEIVER_DATA,
    output logic          RECEIVER_READ,
    output logic          IRQ
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {HS_IDLE, HS_XFER, HS_WAIT} hs_t;

    logic flush;
    assign flush = CONTROL[6];

    logic unused_ctrl;
    assign unused_ctrl = ^{CONTROL[7], CONTROL[4:2]};

    // ---------------- enables ----------------
    logic te_q, re_q;
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            te_q <= 1'b0;
            re_q <= 1'b0;
        end else begin
            te_q <= !(CONTROL[1] | CONTROL[5]);
            re_q <= !(CONTROL[0] | CONTROL[5]);
        end
    end
    assign TE = te_q;
    assign RE = re_q;

    hs_t tx_st, tx_nx, rx_st, rx_nx;

    // ---------------- TX FIFO ----------------
    logic [DW-1:0] tx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [CW-1:0] tx_cnt;
    logic          tx_ovf, tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == CW'(DEPTH));
    assign tx_push  = WRITE & !flush & !tx_full;
    assign tx_pop   = (tx_st == HS_XFER) & !tx_empty;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            tx_ovf <= 1'b0;
        end else if (flush) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            if (WRITE && tx_full) tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wp] <= WDATA;
    end

    // ---------------- RX FIFO ----------------
    logic [DW-1:0] rx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [CW-1:0] rx_cnt;
    logic          rx_ovf, rx_empty, rx_full, rx_ack, rx_push, rx_pop;

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(DEPTH));
    assign rx_ack   = (rx_st == HS_XFER) & !flush;
    assign rx_push  = rx_ack & !rx_full;
    assign rx_pop   = READ & !rx_empty;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            rx_ovf <= 1'b0;
        end else if (flush) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            rx_ovf <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            if (rx_ack && rx_full) rx_ovf <= 1'b1;
        end
    end

    // RX storage is reset so the fall-through head reads 0 out of reset.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
        end else if (rx_push) begin
            rx_mem[rx_wp] <= RECEIVER_DATA;
        end
    end

    assign RDATA = rx_mem[rx_rp];

    // ---------------- sender handshake FSM ----------------
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) tx_st <= HS_IDLE;
        else        tx_st <= tx_nx;
    end

    always_comb begin
        tx_nx = tx_st;
        case (tx_st)
            HS_IDLE: if (te_q && SENDER_EMPTY_STATE && !tx_empty && !flush) tx_nx = HS_XFER;
            HS_XFER: tx_nx = HS_WAIT;
            HS_WAIT: if (!SENDER_EMPTY_STATE) tx_nx = HS_IDLE;
            default: tx_nx = HS_IDLE;
        endcase
    end

    always_comb begin
        SENDER_WRITE = 1'b0;
        SENDER_DATA  = '0;
        if (tx_st == HS_XFER) begin
            SENDER_WRITE = 1'b1;
            SENDER_DATA  = tx_mem[tx_rp];
        end
    end

    // ---------------- receiver handshake FSM ----------------
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) rx_st <= HS_IDLE;
        else        rx_st <= rx_nx;
    end

    always_comb begin
        rx_nx = rx_st;
        case (rx_st)
            HS_IDLE: if (re_q && RECEIVER_FULL_STATE) rx_nx = HS_XFER;
            HS_XFER: rx_nx = HS_WAIT;
            HS_WAIT: if (!RECEIVER_FULL_STATE) rx_nx = HS_IDLE;
            default: rx_nx = HS_IDLE;
        endcase
    end

    always_comb begin
        RECEIVER_READ = 1'b0;
        if (rx_st == HS_XFER) RECEIVER_READ = 1'b1;
    end

    // ---------------- status ----------------
    assign STATUS   = {rx_st != HS_IDLE, tx_st != HS_IDLE, rx_ovf, tx_ovf,
                       rx_full, rx_empty, tx_full, tx_empty};
    assign TX_COUNT = tx_cnt;
    assign RX_COUNT = rx_cnt;

`ifdef SPI_CTRL_IRQ_EN
    logic irq_q;
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) irq_q <= 1'b0;
        else        irq_q <= (tx_empty & te_q) | (!rx_empty & re_q) | tx_ovf | rx_ovf;
    end
    assign IRQ = irq_q;
`else
    assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ctrl_fifo.sv
// Scoreboard bench for spi_ctrl_fifo: random traffic against queue-based FIFO model,
// shifter models on both sides, and a decoupled monitor that does all comparisons.
module tb_spi_ctrl_fifo;
    localparam int DW = 8, DEPTH = 4, CW = 3;

    logic          CLK = 1'b0, CLR_N = 1'b1;
    logic [7:0]    CONTROL = 8'h00;
    logic          WRITE = 1'b0, READ = 1'b0;
    logic [DW-1:0] WDATA = '0;
    logic [DW-1:0] RDATA, SENDER_DATA;
    logic [DW-1:0] RECEIVER_DATA;
    logic [7:0]    STATUS;
    logic [CW-1:0] TX_COUNT, RX_COUNT;
    logic          SENDER_EMPTY_STATE, SENDER_WRITE, TE, RE;
    logic          RECEIVER_FULL_STATE, RECEIVER_READ, IRQ;

    spi_ctrl_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .CONTROL(CONTROL), .WRITE(WRITE), .WDATA(WDATA),
        .READ(READ), .RDATA(RDATA), .STATUS(STATUS), .TX_COUNT(TX_COUNT), .RX_COUNT(RX_COUNT),
        .SENDER_EMPTY_STATE(SENDER_EMPTY_STATE), .SENDER_WRITE(SENDER_WRITE),
        .SENDER_DATA(SENDER_DATA), .TE(TE), .RE(RE), .RECEIVER_FULL_STATE(RECEIVER_FULL_STATE),
        .RECEIVER_DATA(RECEIVER_DATA), .RECEIVER_READ(RECEIVER_READ), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_err = 0;
    int tmo_cnt = 0, tmo_seen = 0;

    // reference model state
    logic [7:0] txq[$], rxq[$];
    bit   tx_ovf_m, rx_ovf_m, te_m, re_m, irq_m, p_snd_go, p_rcv_go;
    int   tx_pre, rx_pre;
    // expectations for the current cycle, consumed by the monitor
    int   e_tx_cnt, e_rx_cnt;
    logic [5:0] e_stat;
    bit   e_te, e_re, e_irq, e_snd, e_rcv;

    // directed words for the receiver shifter model
    logic [7:0] rx_dir [16];
    int   rx_dir_n = 0;
    bit   rx_rand = 1'b0;

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // sender shifter: goes busy after each load strobe for a random time
    initial begin
        SENDER_EMPTY_STATE = 1'b1;
        forever begin
            @(negedge CLK);
            if (SENDER_WRITE) begin
                @(posedge CLK); #1 SENDER_EMPTY_STATE = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge CLK);
                #1 SENDER_EMPTY_STATE = 1'b1;
            end
        end
    end

    // receiver shifter: presents directed words first, then random words when enabled
    initial begin
        int  idx;
        bit  ack;
        idx = 0;
        RECEIVER_FULL_STATE = 1'b0;
        RECEIVER_DATA = '0;
        forever begin
            @(negedge CLK); ack = RECEIVER_READ;
            @(posedge CLK); #1;
            if (ack) RECEIVER_FULL_STATE = 1'b0;
            else if (!RECEIVER_FULL_STATE) begin
                if (idx < rx_dir_n) begin
                    RECEIVER_DATA = rx_dir[idx]; idx++; RECEIVER_FULL_STATE = 1'b1;
                end else if (rx_rand && $urandom_range(0, 2) == 0) begin
                    RECEIVER_DATA = 8'($urandom); RECEIVER_FULL_STATE = 1'b1;
                end
            end
        end
    end

    // scoreboard: snapshot expectations, then apply this cycle's stimulus to the model
    always @(negedge CLK) begin
        if (!CLR_N) begin
            txq.delete(); rxq.delete();
            tx_ovf_m = 0; rx_ovf_m = 0; te_m = 0; re_m = 0; irq_m = 0;
            p_snd_go = 0; p_rcv_go = 0; tx_pre = 0; rx_pre = 0;
        end else begin
            e_tx_cnt = txq.size();
            e_rx_cnt = rxq.size();
            e_stat   = {rx_ovf_m, tx_ovf_m, rxq.size() == DEPTH, rxq.size() == 0,
                        txq.size() == DEPTH, txq.size() == 0};
            e_te = te_m; e_re = re_m; e_irq = irq_m;
            e_snd = p_snd_go; e_rcv = p_rcv_go;

            tx_pre = txq.size();
            rx_pre = rxq.size();
            p_snd_go = !STATUS[6] && te_m && SENDER_EMPTY_STATE && tx_pre != 0 && !CONTROL[6];
            p_rcv_go = !STATUS[7] && re_m && RECEIVER_FULL_STATE;
            irq_m = (tx_pre == 0 && te_m) || (rx_pre != 0 && re_m) || tx_ovf_m || rx_ovf_m;
            te_m  = !(CONTROL[1] || CONTROL[5]);
            re_m  = !(CONTROL[0] || CONTROL[5]);

            if (CONTROL[6]) begin
                txq.delete(); rxq.delete(); tx_ovf_m = 0; rx_ovf_m = 0;
            end else begin
                if (WRITE) begin
                    if (tx_pre == DEPTH) tx_ovf_m = 1;
                    else txq.push_back(WDATA);
                end
                if (RECEIVER_READ) begin
                    if (rx_pre == DEPTH) rx_ovf_m = 1;
                    else rxq.push_back(RECEIVER_DATA);
                end
            end
        end
    end

    // monitor: compares DUT outputs against the scoreboard, pops on each data handshake
    always @(negedge CLK or negedge CLR_N) begin
        #1;
        if (tmo_cnt != tmo_seen) begin
            chk("bounded_wait", tmo_cnt, tmo_seen);
            tmo_seen = tmo_cnt;
        end
        if (!CLR_N) begin
            chk("rst_status",  32'(STATUS), 32'h05);
            chk("rst_tx_cnt",  32'(TX_COUNT), 0);
            chk("rst_rx_cnt",  32'(RX_COUNT), 0);
            chk("rst_swrite",  32'(SENDER_WRITE), 0);
            chk("rst_sdata",   32'(SENDER_DATA), 0);
            chk("rst_rread",   32'(RECEIVER_READ), 0);
            chk("rst_te_re",   32'({TE, RE}), 0);
            chk("rst_rdata",   32'(RDATA), 0);
            chk("rst_irq",     32'(IRQ), 0);
        end else begin
            chk("tx_count",    32'(TX_COUNT), e_tx_cnt);
            chk("rx_count",    32'(RX_COUNT), e_rx_cnt);
            chk("status",      32'(STATUS[5:0]), 32'(e_stat));
            chk("te",          32'(TE), 32'(e_te));
            chk("re",          32'(RE), 32'(e_re));
            chk("sender_write", 32'(SENDER_WRITE), 32'(e_snd));
            chk("receiver_read", 32'(RECEIVER_READ), 32'(e_rcv));
`ifdef SPI_CTRL_IRQ_EN
            chk("irq",         32'(IRQ), 32'(e_irq));
`else
            chk("irq_tied",    32'(IRQ), 0);
`endif
            if (SENDER_WRITE && !CONTROL[6] && txq.size() != 0)
                chk("sender_data", 32'(SENDER_DATA), 32'(txq.pop_front()));
            if (READ && !CONTROL[6] && rx_pre != 0)
                chk("rdata", 32'(RDATA), 32'(rxq.pop_front()));
        end
    end

    initial begin
        bit hit;
        #3 CLR_N = 1'b0;
        CONTROL = 8'h02;
        repeat (3) tick();
        CLR_N = 1'b1;
        tick();

        // TX burst with sender disabled: A1..A4 fill, A5 overflows
        for (int i = 0; i < 5; i++) begin
            WRITE = 1'b1; WDATA = 8'hA1 + 8'(i); tick();
        end
        WRITE = 1'b0;
        repeat (2) tick();
        CONTROL = 8'h00;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick();
            if (TX_COUNT == 0 && !STATUS[6]) hit = 1;
        end
        if (!hit) tmo_cnt++;

        // RX: two words, pop them, then pop once more while empty
        rx_dir[0] = 8'h3C; rx_dir[1] = 8'hC3; rx_dir_n = 2;
        repeat (12) tick();
        for (int i = 0; i < 3; i++) begin
            READ = 1'b1; tick(); READ = 1'b0; tick();
        end

        // RX overflow: five words into the FIFO, then flush
        for (int i = 0; i < 5; i++) rx_dir[2 + i] = 8'h10 + 8'(i);
        rx_dir_n = 7;
        repeat (40) tick();
        CONTROL = 8'h40; repeat (2) tick();
        CONTROL = 8'h00; repeat (4) tick();

        // random traffic: concurrent push/pop, wrap-around, enables and flush pulses
        rx_rand = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            WRITE = ($urandom_range(0, 2) == 0);
            WDATA = 8'($urandom);
            READ  = ($urandom_range(0, 2) == 0);
            if (CONTROL[6]) CONTROL[6] = 1'b0;
            else if ($urandom_range(0, 39) == 0) begin
                CONTROL = 8'($urandom);
                if ($urandom_range(0, 3) != 0) CONTROL[6] = 1'b0;
                if ($urandom_range(0, 1) != 0) CONTROL = CONTROL & 8'hDC;
            end
            tick();
        end
        WRITE = 1'b0; READ = 1'b0; CONTROL = 8'h00; rx_rand = 1'b0;
        repeat (20) tick();

        // asynchronous reset in the middle of a sender load
        WRITE = 1'b1; WDATA = 8'h5A; tick(); WRITE = 1'b0;
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge CLK);
            if (SENDER_WRITE) hit = 1;
        end
        if (!hit) tmo_cnt++;
        #2 CLR_N = 1'b0;
        repeat (2) tick();
        CLR_N = 1'b1;
        tick();

        // drain everything with all paths enabled
        rx_rand = 1'b1;
        for (int c = 0; c < 300; c++) begin
            WRITE = ($urandom_range(0, 1) == 0); WDATA = 8'($urandom);
            READ  = ($urandom_range(0, 1) == 0);
            tick();
        end
        WRITE = 1'b0; rx_rand = 1'b0;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            READ = !STATUS[2];
            tick();
            if (TX_COUNT == 0 && STATUS[2] && STATUS[7:6] == 2'b00 && !RECEIVER_FULL_STATE) hit = 1;
        end
        READ = 1'b0;
        if (!hit) tmo_cnt++;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
